// File: rtl/xbar_slave_arbiter.sv
// Round-robin arbiter for one crossbar slave port, plus the read-order FIFO that steers read responses.
// Grants one cycle after a request and holds it until s_ack. Reads are masked while the order FIFO is full.
module xbar_slave_arbiter #(
    parameter int N_M      = 2,
    parameter int MID_W    = 1,
    parameter int RD_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_M-1:0]   m_req,
    input  logic [N_M-1:0]   m_cmd,
    output logic [N_M-1:0]   m_ack,
    output logic             s_req,
    output logic             s_cmd,
    input  logic             s_ack,
    output logic [MID_W-1:0] sel,
    input  logic             s_resp,
    output logic [MID_W-1:0] resp_sel,
    output logic [N_M-1:0]   m_resp,
    output logic             rd_full,
    output logic             err
);

    localparam int AW = $clog2(RD_DEPTH);
    localparam logic [N_M-1:0] ONE = N_M'(1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [MID_W-1:0] ptr;
    logic [MID_W-1:0] pick;
    logic             found;
    logic             cmd_q;
    logic [N_M-1:0]   eligible;
    logic [N_M-1:0]   rot;

    logic [MID_W-1:0] fifo_mem [RD_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             push;
    logic             pop;
    logic             empty;

    // Only reads are held back by a full order FIFO; writes need no response slot.
    assign eligible = m_req & ~(~m_cmd & {N_M{rd_full}});

    // Rotate so bit 0 is the pointer position; the lowest set bit wins.
    always_comb begin
        rot   = N_M'({eligible, eligible} >> ptr);
        found = 1'b0;
        pick  = '0;
        for (int k = N_M - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                pick  = MID_W'((int'(ptr) + k) % N_M);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            cmd_q <= 1'b0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        sel   <= pick;
                        cmd_q <= m_cmd[pick];
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (s_ack) begin
                        ptr   <= (int'(sel) == N_M - 1) ? '0 : sel + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_req = (state == GRANT);
    assign s_cmd = s_req & cmd_q;
    assign m_ack = (s_req && s_ack) ? (ONE << sel) : '0;

    assign push  = s_req & s_ack & ~cmd_q;
    assign empty = (count == '0);
    assign pop   = s_resp & ~empty;

    always_comb begin
        count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_full <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            rd_full <= (count_next == (AW+1)'(RD_DEPTH));
            if (s_resp && empty) begin
                err <= 1'b1;
            end
        end
    end

    assign resp_sel = empty ? '0 : fifo_mem[rd_ptr];
    assign m_resp   = pop ? (ONE << resp_sel) : '0;

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Bench for xbar_slave_arbiter: vector table, hand-written corner sequences, and a randomised
// phase checked against a behavioural model whose read-order queue acts as the response scoreboard.
module tb_xbar_slave_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] m_req;
    logic [1:0] m_cmd;
    logic [1:0] m_ack;
    logic       s_req;
    logic       s_cmd;
    logic       s_ack;
    logic       sel;
    logic       s_resp;
    logic       resp_sel;
    logic [1:0] m_resp;
    logic       rd_full;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xbar_slave_arbiter #(.N_M(2), .MID_W(1), .RD_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_cmd(m_cmd), .m_ack(m_ack),
        .s_req(s_req), .s_cmd(s_cmd), .s_ack(s_ack), .sel(sel), .s_resp(s_resp),
        .resp_sel(resp_sel), .m_resp(m_resp), .rd_full(rd_full), .err(err)
    );

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [1:0] cmd;
        logic       ack;
        logic       resp;
        logic       e_sreq;
        logic       e_sel;
        logic       e_scmd;
        logic [1:0] e_mack;
        logic [1:0] e_mresp;
        logic       e_rsel;
        logic       e_full;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, input logic [1:0] rq, input logic [1:0] cm,
                               input logic a, input logic rs, input logic sq, input logic sl,
                               input logic sc, input logic [1:0] mk, input logic [1:0] mr,
                               input logic rl, input logic fl, input logic er);
        vec_t t;
        t.rst = r; t.req = rq; t.cmd = cm; t.ack = a; t.resp = rs;
        t.e_sreq = sq; t.e_sel = sl; t.e_scmd = sc; t.e_mack = mk; t.e_mresp = mr;
        t.e_rsel = rl; t.e_full = fl; t.e_err = er;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_sreq, input logic e_sel,
                             input logic e_scmd, input logic [1:0] e_mack,
                             input logic [1:0] e_mresp, input logic e_rsel,
                             input logic e_full, input logic e_err);
        chk({tag, " s_req"},    8'(s_req),    8'(e_sreq));
        chk({tag, " sel"},      8'(sel),      8'(e_sel));
        chk({tag, " s_cmd"},    8'(s_cmd),    8'(e_scmd));
        chk({tag, " m_ack"},    8'(m_ack),    8'(e_mack));
        chk({tag, " m_resp"},   8'(m_resp),   8'(e_mresp));
        chk({tag, " resp_sel"}, 8'(resp_sel), 8'(e_rsel));
        chk({tag, " rd_full"},  8'(rd_full),  8'(e_full));
        chk({tag, " err"},      8'(err),      8'(e_err));
    endtask

    task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] cm,
                         input logic a, input logic rs);
        rst = r; m_req = rq; m_cmd = cm; s_ack = a; s_resp = rs;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model for the randomised phase.
    int         mst, msel, mcmd, mptr;
    int         q[$];
    logic [1:0] acked;

    initial begin
        vec_t t;

        // rst, req, cmd, ack, resp | s_req, sel, s_cmd, m_ack, m_resp, resp_sel, rd_full, err
        tbl.push_back(v(0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b01, 2'b01, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b01, 2'b01, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b01, 2'b01, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b01, 2'b01, 1, 0, 1, 0, 1, 2'b01, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(v(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b11, 2'b11, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b11, 2'b11, 1, 0, 1, 0, 1, 2'b01, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b11, 2'b11, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b11, 2'b11, 1, 0, 1, 1, 1, 2'b10, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b11, 2'b11, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b11, 2'b11, 1, 0, 1, 0, 1, 2'b01, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b11, 2'b11, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b11, 2'b11, 1, 0, 1, 1, 1, 2'b10, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b10, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b10, 2'b00, 1, 0, 1, 1, 0, 2'b10, 2'b00, 0, 0, 0));
        tbl.push_back(v(0, 2'b01, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 0));
        tbl.push_back(v(0, 2'b01, 2'b00, 1, 0, 1, 0, 0, 2'b01, 2'b00, 1, 0, 0));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b10, 1, 0, 0));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0));
        tbl.push_back(v(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));

        drive(1, 2'b00, 2'b00, 0, 0);
        cyc();
        cyc();
        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            drive(t.rst, t.req, t.cmd, t.ack, t.resp);
            check_all($sformatf("vec%0d", i), t.e_sreq, t.e_sel, t.e_scmd, t.e_mack,
                      t.e_mresp, t.e_rsel, t.e_full, t.e_err);
            cyc();
        end

        // Fill the order FIFO with four m0 reads, then check read masking.
        drive(1, 2'b00, 2'b00, 0, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(0, 2'b01, 2'b00, 1, 0);
            cyc();
            cyc();
        end
        drive(0, 2'b00, 2'b00, 0, 0);
        chk("full_set", 8'(rd_full), 8'd1);
        drive(0, 2'b11, 2'b10, 0, 0);
        chk("full_idle_sreq", 8'(s_req), 8'd0);
        cyc();
        chk("full_wr_sreq", 8'(s_req), 8'd1);
        chk("full_wr_sel", 8'(sel), 8'd1);
        chk("full_wr_scmd", 8'(s_cmd), 8'd1);
        drive(0, 2'b11, 2'b10, 1, 0);
        chk("full_wr_mack", 8'(m_ack), 8'b10);
        cyc();
        drive(0, 2'b01, 2'b00, 0, 0);
        cyc();
        chk("full_rd_masked", 8'(s_req), 8'd0);
        drive(0, 2'b01, 2'b00, 0, 1);
        chk("full_pop_mresp", 8'(m_resp), 8'b01);
        chk("full_pop_sreq", 8'(s_req), 8'd0);
        cyc();
        drive(0, 2'b01, 2'b00, 0, 0);
        chk("full_clr", 8'(rd_full), 8'd0);
        chk("full_clr_sreq", 8'(s_req), 8'd0);
        cyc();
        chk("full_rd_grant", 8'(s_req), 8'd1);
        chk("full_rd_sel", 8'(sel), 8'd0);
        chk("full_rd_scmd", 8'(s_cmd), 8'd0);
        drive(0, 2'b01, 2'b00, 1, 0);
        cyc();
        drive(0, 2'b00, 2'b00, 0, 0);
        chk("full_reset", 8'(rd_full), 8'd1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 2'b00, 2'b00, 0, 1);
            chk($sformatf("drain%0d m_resp", i), 8'(m_resp), 8'b01);
            cyc();
        end
        drive(0, 2'b00, 2'b00, 0, 0);
        chk("drain_full", 8'(rd_full), 8'd0);

        // Response with an empty FIFO sets the sticky error.
        drive(0, 2'b00, 2'b00, 0, 1);
        chk("empty_mresp", 8'(m_resp), 8'b00);
        chk("empty_err_pre", 8'(err), 8'd0);
        cyc();
        drive(0, 2'b00, 2'b00, 0, 0);
        chk("err_set", 8'(err), 8'd1);
        cyc();
        cyc();
        chk("err_sticky", 8'(err), 8'd1);

        // Reset in the middle of a grant with two reads outstanding.
        drive(1, 2'b00, 2'b00, 0, 0);
        cyc();
        drive(0, 2'b00, 2'b00, 0, 0);
        chk("err_clr", 8'(err), 8'd0);
        drive(0, 2'b10, 2'b00, 0, 0);
        cyc();
        drive(0, 2'b10, 2'b00, 1, 0);
        cyc();
        drive(0, 2'b01, 2'b00, 0, 0);
        cyc();
        drive(0, 2'b01, 2'b00, 1, 0);
        cyc();
        drive(0, 2'b10, 2'b10, 0, 0);
        cyc();
        chk("mid_sreq", 8'(s_req), 8'd1);
        chk("mid_sel", 8'(sel), 8'd1);
        chk("mid_rsel", 8'(resp_sel), 8'd1);
        drive(1, 2'b10, 2'b10, 0, 0);
        cyc();
        drive(0, 2'b00, 2'b00, 0, 0);
        chk("rst_sreq", 8'(s_req), 8'd0);
        chk("rst_full", 8'(rd_full), 8'd0);
        chk("rst_rsel", 8'(resp_sel), 8'd0);
        drive(0, 2'b11, 2'b11, 0, 0);
        cyc();
        chk("rst_ptr_sreq", 8'(s_req), 8'd1);
        chk("rst_ptr_sel", 8'(sel), 8'd0);
        drive(0, 2'b11, 2'b11, 1, 0);
        cyc();
        drive(0, 2'b00, 2'b00, 0, 1);
        chk("rst_resp_mresp", 8'(m_resp), 8'b00);
        cyc();
        drive(0, 2'b00, 2'b00, 0, 0);
        chk("rst_resp_err", 8'(err), 8'd1);

        // Randomised traffic against the model.
        drive(1, 2'b00, 2'b00, 0, 0);
        cyc();
        mst = 0; msel = 0; mcmd = 0; mptr = 0;
        q.delete();
        acked = 2'b00;
        for (int c = 0; c < 400; c++) begin
            logic [1:0] rq, cm, e_mack, e_mresp;
            logic       a, rs, full;
            int         hd;
            rq = m_req;
            cm = m_cmd;
            for (int i = 0; i < 2; i++) begin
                if (acked[i]) begin
                    rq[i] = 1'b0;
                end else if (!rq[i] && $urandom_range(2) == 0) begin
                    rq[i] = 1'b1;
                    cm[i] = 1'($urandom_range(1));
                end
            end
            a  = 1'($urandom_range(1));
            rs = (q.size() > 0) && ($urandom_range(2) == 0);
            drive(0, rq, cm, a, rs);

            hd      = (q.size() > 0) ? q[0] : 0;
            full    = (q.size() == 4);
            e_mack  = (mst == 1 && a) ? ((msel == 1) ? 2'b10 : 2'b01) : 2'b00;
            e_mresp = (rs && q.size() > 0) ? ((hd == 1) ? 2'b10 : 2'b01) : 2'b00;
            check_all($sformatf("rnd%0d", c), 1'(mst), 1'(msel), (mst == 1) ? 1'(mcmd) : 1'b0,
                      e_mack, e_mresp, 1'(hd), full, 1'b0);

            if (rs && q.size() > 0) begin
                void'(q.pop_front());
            end
            if (mst == 1) begin
                if (a) begin
                    if (mcmd == 0) begin
                        q.push_back(msel);
                    end
                    mptr = (msel + 1) % 2;
                    mst  = 0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    int idx;
                    idx = (mptr + k) % 2;
                    if (mst == 0 && rq[idx] && !(!cm[idx] && full)) begin
                        msel = idx;
                        mcmd = int'(cm[idx]);
                        mst  = 1;
                    end
                end
            end
            acked = e_mack;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xbar_slave_arbiter.md
# xbar_slave_arbiter

Per-slave-port round-robin arbiter for the crossbar. It takes request/command lines from all masters, grants one at a time to the slave port, and drives the crossbar's request mux select. It also records the order of accepted reads so each slave read response is steered back to the master that issued it. One instance sits in front of every slave port; the crossbar datapath muxes are controlled by its `sel`/`resp_sel` outputs.

## Interface
- `N_M`, default 2: number of masters, 2..8.
- `MID_W`, default 1: master index width, equal to $clog2(N_M) (minimum 1).
- `RD_DEPTH`, default 4: outstanding-read order FIFO depth, power of two, at least 2.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m_req`  in  N_M  request from each master; held until that master's ack.
- `m_cmd`  in  N_M  per-master command: 1 = write, 0 = read; stable while `m_req` is high.
- `m_ack`  out  N_M  one-hot; the granted master's bit equals `s_ack`.
- `s_req`  out  1  request to the slave.
- `s_cmd`  out  1  command of the granted master.
- `s_ack`  in  1  slave accepted the current request.
- `sel`  out  MID_W  index of the granted master (address/wdata mux select).
- `s_resp`  in  1  slave read-data valid, one cycle per read.
- `resp_sel`  out  MID_W  master index for the current `s_resp` (rdata mux select).
- `m_resp`  out  N_M  one-hot read-response strobe to masters.
- `rd_full`  out  1  order FIFO holds RD_DEPTH entries.
- `err`  out  1  sticky: `s_resp` was received while the FIFO was empty.

## Operation
- FSM states:
  - IDLE: `s_req` = 0. Compute eligible = `m_req` & ~(read & `rd_full`). If eligible is nonzero, pick the first set bit at or after pointer `ptr` (wrapping modulo N_M), register it into `sel`, and go to GRANT.
  - GRANT: `s_req` = 1, `s_cmd` = `m_cmd[sel]`, `sel` is held. Stay until `s_ack` = 1. In the `s_ack` cycle:
    - `m_ack[sel]` = 1
    - `ptr` <= `sel`+1, wrapping at N_M
    - if the command is a read, push `sel` into the order FIFO
    - return to IDLE.
- Reads are masked while `rd_full` = 1; writes are not affected. Only `ptr` rotates, so a masked reader keeps its turn once the FIFO drains.
- Response path:
  - `resp_sel` = FIFO head (combinational). `m_resp` = `s_resp` ? onehot(head) : 0.
  - `s_resp` pops the FIFO.
- FIFO boundaries:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push while full cannot happen because reads are masked.
  - Pop while empty: `m_resp` = 0, no pointer change, `err` <= 1.
- A master that drops `m_req` while granted is a protocol violation. The arbiter holds the grant until `s_ack` anyway.
- Reset values: `ptr`=0, state IDLE, `sel`=0, `s_req`=0, `s_cmd`=0, `m_ack`=0, `m_resp`=0, FIFO empty, `rd_full`=0, `resp_sel`=0, `err`=0.
- Reset mid-transfer: the next cycle shows `s_req`=0 and the FIFO empty. Outstanding reads are discarded; a later `s_resp` sets `err`.

## Timing
- `m_req` rises in cycle t while IDLE → `s_req`=1 and `sel` valid in t+1.
- `s_ack` in cycle t+k → `m_ack` in the same cycle (combinational). State is IDLE in t+k+1, and the next `s_req` can appear no earlier than t+k+2. Minimum 2 cycles per transfer.
- `sel`, `s_cmd` and `s_req` are registered or state-decoded and stable for the whole GRANT phase.
- `resp_sel`/`m_resp` are combinational from the FIFO head and `s_resp`; zero added latency.
- A read pushed in the `s_ack` cycle is visible at the head in the next cycle. A `s_resp` in the same cycle as its own `s_ack` is therefore an error.
- `rd_full` is registered and updates the cycle after the push/pop that changes the count.

## Test plan
- Single master: N_M=2, m0 write, `s_ack` 3 cycles after `s_req` → `sel`=0, `m_ack`=01 in the ack cycle, `s_req` low the next cycle, FIFO unchanged.
- Round robin: m0 and m1 request continuously, `s_ack` immediate → grant order 0,1,0,1 with `s_req` high every other cycle.
- Read ordering: m1 read acked, then m0 read acked, then 2 `s_resp` pulses → `m_resp`=10, then 01; `resp_sel`=1, then 0.
- FIFO full: RD_DEPTH=4, 4 reads acked with no `s_resp` → `rd_full`=1. A pending m0 read is not granted while a pending m1 write is granted. One `s_resp` → `rd_full`=0 next cycle, and the m0 read is granted after that.
- Error: `s_resp` with an empty FIFO → `err`=1, stays 1 until `rst`.
- Reset mid-GRANT with 2 reads outstanding: `rst` for 1 cycle → next cycle `s_req`=0, `ptr`=0, `rd_full`=0. A subsequent `s_resp` sets `err`.
